// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and default constants for the frequency meter
//
// Purpose : state encoding of the measurement FSM and default parameter values
//           used by freq_meter and sync_edge_det.
// Ports   : none (package).
// Config  : FREQ_METER_PERIOD_EN (used in freq_meter) adds the period outputs.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_t;

  localparam int DEF_GATE_CYCLES = 1024;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer followed by a registered rising-edge detector
//
// Purpose : brings an asynchronous input into the clk domain and emits a one-cycle
//           pulse per rising edge, SYNC_STAGES+1 cycles after the input rises.
// Ports   : clk   - clock
//           rst_n - synchronous active-low reset
//           din   - asynchronous input
//           rise  - one-cycle rising-edge pulse (registered)
module sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_dly  <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_dly;
    end
  end

  assign rise = r_rise;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter measuring the frequency of an asynchronous signal
//
// Purpose : after start, waits for a first edge of sig_in, then counts rising edges
//           over GATE_CYCLES clk cycles; optionally repeats windows back-to-back.
// Ports   : clk          - sole clock
//           rst_n        - synchronous active-low reset
//           sig_in       - asynchronous signal under measurement
//           start        - one-cycle request to begin (ignored while busy)
//           continuous   - level, sampled at the last gate cycle: 1 = start next window
//           busy         - FSM not in IDLE
//           cnt_out      - saturated edge count of the last completed window
//           cnt_valid    - one-cycle pulse when cnt_out/overflow update
//           overflow     - last completed window reached the saturation value
//           period_out   - clk cycles between the last two edges (FREQ_METER_PERIOD_EN)
//           period_valid - one-cycle pulse when period_out updates (FREQ_METER_PERIOD_EN)
// Config  : FREQ_METER_PERIOD_EN enables the free-running period measurement.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             overflow
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid
`endif
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             w_rise;
  logic [CNT_W-1:0] w_edge_next;

  state_t           r_state;
  logic             r_busy;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_cnt_out;
  logic             r_cnt_valid;
  logic             r_overflow;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sig_in),
    .rise (w_rise)
  );

  // Edge count including this cycle's pulse, held at CNT_MAX once reached.
  assign w_edge_next = (w_rise && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_gate_cnt  <= '0;
      r_edge_cnt  <= '0;
      r_cnt_out   <= '0;
      r_cnt_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_cnt_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // An edge coinciding with start is deliberately not used as trigger.
          if (start) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
          end
        end
        ARM: begin
          // The triggering edge opens the window but is not itself counted.
          if (w_rise) begin
            r_state    <= GATE;
            r_gate_cnt <= GATE_LOAD;
            r_edge_cnt <= '0;
          end
        end
        GATE: begin
          if (r_gate_cnt == '0) begin
            r_cnt_out   <= w_edge_next;
            r_overflow  <= (w_edge_next == CNT_MAX);
            r_cnt_valid <= 1'b1;
            r_edge_cnt  <= '0;
            // Reloading here makes the next cycle the first of the new window.
            if (continuous) begin
              r_gate_cnt <= GATE_LOAD;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gate_cnt <= r_gate_cnt - GW'(1);
            r_edge_cnt <= w_edge_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign cnt_out   = r_cnt_out;
  assign cnt_valid = r_cnt_valid;
  assign overflow  = r_overflow;

`ifdef FREQ_METER_PERIOD_EN
  // r_since holds the distance in cycles from the previous edge pulse; it is
  // preloaded to 1 on an edge so that it reads exactly P at the next edge.
  logic [CNT_W-1:0] r_since;
  logic [CNT_W-1:0] r_period_out;
  logic             r_period_valid;
  logic             r_seen_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_since        <= '0;
      r_period_out   <= '0;
      r_period_valid <= 1'b0;
      r_seen_edge    <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (w_rise) begin
        r_since     <= CNT_W'(1);
        r_seen_edge <= 1'b1;
        if (r_seen_edge) begin
          r_period_out   <= r_since;
          r_period_valid <= 1'b1;
        end
      end else if (r_since != CNT_MAX) begin
        r_since <= r_since + CNT_W'(1);
      end
    end
  end

  assign period_out   = r_period_out;
  assign period_valid = r_period_valid;
`else
  // Without the period option only the gated edge counter is built.
`endif

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1024, measurement window length in clk cycles (legal 2..65536).
REQ-002 SHALL have parameter CNT_W, default 16, width of edge count and period outputs.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sig_in (legal >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sig_in  input  1  signal under measurement, asynchronous to clk.
REQ-007 SHALL have port start  input  1  single-cycle request to begin measuring.
REQ-008 SHALL have port continuous  input  1  level; 1 = restart a new window back-to-back.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port cnt_out  output  CNT_W  rising-edge count of last completed window.
REQ-011 SHALL have port cnt_valid  output  1  one-cycle pulse when cnt_out updates.
REQ-012 SHALL have port overflow  output  1  last completed window saturated.

Function
REQ-013 SHALL pass sig_in through SYNC_STAGES flops, then rising-edge detect; edge pulse one cycle, SYNC_STAGES+1 cycles after sig_in rise.
REQ-014 SHALL implement FSM states IDLE, ARM, GATE.
REQ-015 IDLE: start=1 -> ARM; edge pulse in same cycle as start ignored.
REQ-016 ARM: first edge pulse -> GATE; triggering edge not counted; gate counter loaded GATE_CYCLES-1, edge counter cleared.
REQ-017 GATE: edge counter += edge pulse each cycle, saturating at 2^CNT_W-1; gate counter decrements.
REQ-018 GATE last cycle (gate counter 0): edge in that cycle included; next cycle cnt_out = final count, overflow = saturation reached, cnt_valid = 1.
REQ-019 GATE last cycle with continuous=1: stay in GATE, reload gate counter, clear edge counter; no gap between windows; else -> IDLE.
REQ-020 continuous sampled only at last GATE cycle; deassert mid-window completes current window then IDLE.
REQ-021 start ignored while busy=1.
REQ-022 cnt_out and overflow hold value until next cnt_valid.
REQ-023 ARM waits indefinitely with busy=1 if no edge arrives.

Reset
REQ-024 rst_n=0 at posedge clk: FSM -> IDLE; synchronizer, counters, busy, cnt_out, cnt_valid, overflow (and period outputs) -> 0.
REQ-025 Reset mid-window discards partial count; no cnt_valid produced.

Configuration
REQ-026 FREQ_METER_PERIOD_EN defined: add outputs period_out (CNT_W) and period_valid (1); on each edge pulse after the first since reset, period_out = clk cycles since previous edge pulse, saturating at 2^CNT_W-1, period_valid pulses one cycle; independent of FSM.
REQ-027 FREQ_METER_PERIOD_EN undefined: ports and period logic absent; all other behaviour identical.

Structure
REQ-028 Package freq_meter_pkg SHALL hold state enum typedef (IDLE, ARM, GATE) and default constants for GATE_CYCLES, CNT_W, SYNC_STAGES.
REQ-029 Sub-module sync_edge_det SHALL contain synchronizer and rising-edge detector (params SYNC_STAGES; ports clk, rst_n, din, rise).
REQ-030 Gate counter width SHALL be $clog2(GATE_CYCLES).

Verification
REQ-031 sig_in toggling every 4 clk, GATE_CYCLES=1024, continuous=0, start -> single cnt_valid, cnt_out=128, overflow=0, busy returns 0.
REQ-032 sig_in period 10 clk, GATE_CYCLES=1000, continuous=1 -> cnt_valid pulses exactly 1000 cycles apart, each cnt_out=100.
REQ-033 CNT_W=4, sig_in period 2, GATE_CYCLES=64 -> cnt_out=15, overflow=1; next window with period 8 -> cnt_out=8, overflow=0.
REQ-034 sig_in held 0, start -> busy=1 in ARM, no cnt_valid; rst_n low one cycle -> busy=0, all outputs 0.
REQ-035 start pulsed during GATE ignored; continuous dropped mid-window -> exactly one more cnt_valid then IDLE.
REQ-036 With FREQ_METER_PERIOD_EN, sig_in period 37 -> period_out=37 with period_valid on each edge from second edge onward.
